// File: rtl/lcb_trig_pkg.sv
// Shared types and helpers for the LCB trigger path: FSM encoding, counter saturation, width helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lcb_trig_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    LOCKOUT = 2'd2
  } trig_state_e;

  // Widest counter the saturating helper supports.
  localparam int SAT_W = 32;

  // Increment that sticks at all-ones for a counter 'width' bits wide.
  // Callers zero-extend into SAT_W bits and truncate the result back.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val, input int width);
    logic [SAT_W-1:0] ceiling;
    ceiling = {SAT_W{1'b1}} >> (SAT_W - width);
    return (val >= ceiling) ? val : val + SAT_W'(1);
  endfunction

  // Bits needed to hold values 0 .. value-1 (ceil log2).
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_trigger_detector_if.sv
// Bundle between synchronizer/sequencer side and the trigger detector.
// Latency: n/a (wires only).
// Backpressure: none; all signals are level/pulse, no handshake.
// Ports: din_sync, din_stable, arm, disarm, clear_count (to detector);
//        trig, armed, busy, trig_count, missed_count (from detector,
//        missed_count only when SYNC_TRIGGER_MISSED_COUNT_EN is defined).
interface sync_trigger_detector_if #(
  parameter int COUNT_WIDTH = 16
);
  logic                   din_sync;
  logic                   din_stable;
  logic                   arm;
  logic                   disarm;
  logic                   clear_count;
  logic                   trig;
  logic                   armed;
  logic                   busy;
  logic [COUNT_WIDTH-1:0] trig_count;
`ifdef SYNC_TRIGGER_MISSED_COUNT_EN
  logic [COUNT_WIDTH-1:0] missed_count;
`endif

  modport master (
    output din_sync, din_stable, arm, disarm, clear_count,
    input  trig, armed, busy, trig_count
`ifdef SYNC_TRIGGER_MISSED_COUNT_EN
    , input missed_count
`endif
  );

  modport slave (
    input  din_sync, din_stable, arm, disarm, clear_count,
    output trig, armed, busy, trig_count
`ifdef SYNC_TRIGGER_MISSED_COUNT_EN
    , output missed_count
`endif
  );

endinterface

// File: rtl/lockout_timer.sv
// Loadable down-counter pacing the post-trigger lockout window.
// Latency: load/clear/dec take effect on the next clock; done is decoded from the register.
// Backpressure: none.
// Ports: clk, rst (async, active-high), load (to CYCLES), clear (to 0),
//        dec (count down, holds at 0), done (count == 1, last lockout cycle).
module lockout_timer
  import lcb_trig_pkg::*;
#(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clear,
  input  logic dec,
  output logic done
);
  localparam int RAW_W = clogb2(CYCLES + 1);
  localparam int W     = (RAW_W < 1) ? 1 : RAW_W;

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      count <= '0;
    else if (clear)               count <= '0;
    else if (load)                count <= W'(CYCLES);
    else if (dec && count != '0)  count <= count - W'(1);
  end

  assign done = (count == W'(1));

endmodule

// File: rtl/sync_trigger_detector.sv
// Qualified edge-to-trigger stage: stable-history edge on din_sync fires a one-cycle trig while armed, then locks out.
// Latency: edge in cycle N -> trig/busy/trig_count in N+1; arm/disarm visible one cycle later.
// Backpressure: none; edges during lockout are counted as missed (SYNC_TRIGGER_MISSED_COUNT_EN) or dropped.
// Ports: clk, rst (async, active-high), bus (sync_trigger_detector_if.slave).
// Optional feature macro: SYNC_TRIGGER_MISSED_COUNT_EN adds missed_count.
module sync_trigger_detector
  import lcb_trig_pkg::*;
#(
  parameter int COUNT_WIDTH    = 16,
  parameter int LOCKOUT_CYCLES = 4,
  parameter int EDGE_RISING    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  sync_trigger_detector_if.slave   bus
);
  localparam logic EDGE_LVL = (EDGE_RISING != 0);

  trig_state_e            state;
  logic                   prev_sync;
  logic                   edge_ok;
  logic                   fire;
  logic                   tmr_load;
  logic                   lock_tick;
  logic                   tmr_done;
  logic                   trig_q;
  logic                   armed_q;
  logic                   busy_q;
  logic [COUNT_WIDTH-1:0] trig_cnt;

  // din_stable lags din_sync, so on the edge cycle it vouches for the
  // pre-edge level; glitches and back-to-back toggles fail this test.
  assign edge_ok   = (bus.din_sync == EDGE_LVL) && (prev_sync != EDGE_LVL) && bus.din_stable;
  // disarm wins over a coincident edge.
  assign fire      = (state == ARMED) && edge_ok && !bus.disarm;
  // With a zero-length window the FSM stays in ARMED after a trigger.
  assign tmr_load  = fire && (LOCKOUT_CYCLES != 0);
  assign lock_tick = (state == LOCKOUT) && !bus.disarm;

  lockout_timer #(.CYCLES(LOCKOUT_CYCLES)) u_timer (
    .clk,
    .rst,
    .load  (tmr_load),
    .clear (bus.disarm),
    .dec   (lock_tick),
    .done  (tmr_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      prev_sync <= 1'b0;
      trig_q    <= 1'b0;
      armed_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      prev_sync <= bus.din_sync;
      trig_q    <= fire;
      if (bus.disarm) begin
        state   <= IDLE;
        armed_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (bus.arm) begin
            state   <= ARMED;
            armed_q <= 1'b1;
          end
          ARMED: if (tmr_load) begin
            state  <= LOCKOUT;
            busy_q <= 1'b1;
          end
          // done marks the last lockout cycle; ARMED again on the next.
          LOCKOUT: if (tmr_done) begin
            state  <= ARMED;
            busy_q <= 1'b0;
          end
          default: begin
            state   <= IDLE;
            armed_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  // A clear coinciding with an increment leaves the count at 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  trig_cnt <= '0;
    else if (bus.clear_count) trig_cnt <= fire ? COUNT_WIDTH'(1) : '0;
    else if (fire)            trig_cnt <= COUNT_WIDTH'(sat_inc(SAT_W'(trig_cnt), COUNT_WIDTH));
  end

`ifdef SYNC_TRIGGER_MISSED_COUNT_EN
  logic                   miss;
  logic [COUNT_WIDTH-1:0] miss_cnt;

  assign miss = (state == LOCKOUT) && edge_ok && !bus.disarm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  miss_cnt <= '0;
    else if (bus.clear_count) miss_cnt <= miss ? COUNT_WIDTH'(1) : '0;
    else if (miss)            miss_cnt <= COUNT_WIDTH'(sat_inc(SAT_W'(miss_cnt), COUNT_WIDTH));
  end

  assign bus.missed_count = miss_cnt;
`endif

  assign bus.trig       = trig_q;
  assign bus.armed      = armed_q;
  assign bus.busy       = busy_q;
  assign bus.trig_count = trig_cnt;

endmodule
